// File: rtl/spi_ram_burst_if.sv
// Word-level link between the SPI slave shifter and the burst RAM command decoder.
interface spi_ram_burst_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic [DATA_WIDTH+1:0] din;
   logic                  rx_valid;
   logic                  tx_ready;
   logic                  err_clr;
   logic [DATA_WIDTH-1:0] dout;
   logic                  tx_valid;
   logic                  err_ovf;
   logic                  err_range;

   modport master (
      output din, rx_valid, tx_ready, err_clr,
      input  dout, tx_valid, err_ovf, err_range
   );

   modport slave (
      input  din, rx_valid, tx_ready, err_clr,
      output dout, tx_valid, err_ovf, err_range
   );
endinterface

// File: rtl/spi_ram_burst.sv
// Command-decoded single-port RAM with independent write/read pointers, optional
// burst auto-increment, held read-data handshake and sticky error flags.
module spi_ram_burst #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256,
   parameter int AUTO_INC   = 1
) (
   input logic            CLK,
   input logic            rst_n,
   spi_ram_burst_if.slave bus
);
   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } opcode_t;

   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  tx_valid_q;
   logic                  err_ovf_q;
   logic                  err_range_q;

   opcode_t               op;
   logic [DATA_WIDTH-1:0] payload;
   logic                  wr_cmd;
   logic                  rd_drop;
   logic                  wr_ok;
   logic                  rd_ok;

   assign op      = opcode_t'(bus.din[DATA_WIDTH+1:DATA_WIDTH]);
   assign payload = bus.din[DATA_WIDTH-1:0];
   assign wr_cmd  = bus.rx_valid && (op == OP_WR_DATA);
   assign rd_drop = tx_valid_q && !bus.tx_ready;
   assign wr_ok   = {1'b0, wr_ptr} < DEPTH;
   assign rd_ok   = {1'b0, rd_ptr} < DEPTH;

   // Wrap at MEM_DEPTH rather than at the natural pointer width.
   function automatic logic [ADDR_WIDTH-1:0] bump(input logic [ADDR_WIDTH-1:0] p);
      return ({1'b0, p} == DEPTH - (ADDR_WIDTH+1)'(1)) ? '0 : p + ADDR_WIDTH'(1);
   endfunction

   always_ff @(posedge CLK) begin
      if (wr_cmd && wr_ok) begin
         mem[wr_ptr] <= payload;
      end
   end

   // Later assignments override earlier ones, so a reload beats the handshake
   // clear and an error set beats err_clr on the same edge.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         dout_q      <= '0;
         tx_valid_q  <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         if (tx_valid_q && bus.tx_ready) begin
            tx_valid_q <= 1'b0;
         end
         if (bus.err_clr) begin
            err_ovf_q   <= 1'b0;
            err_range_q <= 1'b0;
         end
         if (bus.rx_valid) begin
            unique case (op)
               OP_WR_ADDR: wr_ptr <= payload[ADDR_WIDTH-1:0];
               OP_WR_DATA: begin
                  if (!wr_ok) begin
                     err_range_q <= 1'b1;
                  end else if (AUTO_INC != 0) begin
                     wr_ptr <= bump(wr_ptr);
                  end
               end
               OP_RD_ADDR: rd_ptr <= payload[ADDR_WIDTH-1:0];
               OP_RD_DATA: begin
                  if (rd_drop) begin
                     err_ovf_q <= 1'b1;
                  end else begin
                     tx_valid_q <= 1'b1;
                     if (rd_ok) begin
                        dout_q <= mem[rd_ptr];
                        if (AUTO_INC != 0) begin
                           rd_ptr <= bump(rd_ptr);
                        end
                     end else begin
                        dout_q      <= '0;
                        err_range_q <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.dout      = dout_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.err_ovf   = err_ovf_q;
   assign bus.err_range = err_range_q;
endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: three configurations checked every cycle
// against a plain behavioural model, plus hand-computed pins.
module tb_spi_ram_burst;
   logic CLK;
   logic rst_n;

   spi_ram_burst_if #(.DATA_WIDTH(8))  bus0 ();
   spi_ram_burst_if #(.DATA_WIDTH(8))  bus1 ();
   spi_ram_burst_if #(.DATA_WIDTH(16)) bus2 ();

   spi_ram_burst u0 (.CLK(CLK), .rst_n(rst_n), .bus(bus0.slave));
   spi_ram_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1))
      u1 (.CLK(CLK), .rst_n(rst_n), .bus(bus1.slave));
   spi_ram_burst #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .MEM_DEPTH(1024), .AUTO_INC(0))
      u2 (.CLK(CLK), .rst_n(rst_n), .bus(bus2.slave));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int checks = 0;
   int errors = 0;
   bit checking = 0;

   int pDepth [3] = '{256, 200, 1024};
   int pAw    [3] = '{8, 8, 10};
   int pDmask [3] = '{'hFF, 'hFF, 'hFFFF};
   bit pAuto  [3] = '{1'b1, 1'b1, 1'b0};

   logic [15:0] mMem [3][1024];
   int          mWp  [3];
   int          mRp  [3];
   logic [15:0] mDout[3];
   bit          mTxv [3];
   bit          mOvf [3];
   bit          mRng [3];

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic getOut(input int i, output logic [15:0] d, output logic v, output logic o, output logic r);
      case (i)
         0: begin d = {8'h00, bus0.dout}; v = bus0.tx_valid; o = bus0.err_ovf; r = bus0.err_range; end
         1: begin d = {8'h00, bus1.dout}; v = bus1.tx_valid; o = bus1.err_ovf; r = bus1.err_range; end
         default: begin d = bus2.dout; v = bus2.tx_valid; o = bus2.err_ovf; r = bus2.err_range; end
      endcase
   endtask

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         mWp[i] = 0; mRp[i] = 0; mDout[i] = '0;
         mTxv[i] = 0; mOvf[i] = 0; mRng[i] = 0;
      end
   endtask

   // Next-state of one instance from the opcode rules, using plain integers.
   task automatic modelStep(input int i, input logic [1:0] op, input logic [15:0] pl,
                            input bit rxv, input bit txr, input bit clr);
      bit ovfEvt = 0;
      bit rngEvt = 0;
      bit accept;
      int p;
      p = int'(pl) & pDmask[i];
      accept = mTxv[i] && txr;
      if (rxv) begin
         case (op)
            2'd0: mWp[i] = p % (1 << pAw[i]);
            2'd1: begin
               if (mWp[i] >= pDepth[i]) rngEvt = 1;
               else begin
                  mMem[i][mWp[i]] = 16'(p);
                  if (pAuto[i]) mWp[i] = (mWp[i] + 1) % pDepth[i];
               end
            end
            2'd2: mRp[i] = p % (1 << pAw[i]);
            default: begin
               if (mTxv[i] && !txr) ovfEvt = 1;
               else begin
                  accept = 0;
                  mTxv[i] = 1;
                  if (mRp[i] >= pDepth[i]) begin
                     mDout[i] = '0;
                     rngEvt = 1;
                  end else begin
                     mDout[i] = mMem[i][mRp[i]];
                     if (pAuto[i]) mRp[i] = (mRp[i] + 1) % pDepth[i];
                  end
               end
            end
         endcase
      end
      if (accept) mTxv[i] = 0;
      if (clr) begin mOvf[i] = 0; mRng[i] = 0; end
      if (ovfEvt) mOvf[i] = 1;
      if (rngEvt) mRng[i] = 1;
   endtask

   task automatic idleInputs();
      bus0.din = '0; bus0.rx_valid = 0; bus0.tx_ready = 0; bus0.err_clr = 0;
      bus1.din = '0; bus1.rx_valid = 0; bus1.tx_ready = 0; bus1.err_clr = 0;
      bus2.din = '0; bus2.rx_valid = 0; bus2.tx_ready = 0; bus2.err_clr = 0;
   endtask

   // One clock of stimulus on a single instance; the others sit idle.
   task automatic applyStimulus(input int i, input logic [1:0] op, input logic [15:0] pl,
                                input bit rxv, input bit txr, input bit clr);
      case (i)
         0: begin bus0.din = {op, pl[7:0]}; bus0.rx_valid = rxv; bus0.tx_ready = txr; bus0.err_clr = clr; end
         1: begin bus1.din = {op, pl[7:0]}; bus1.rx_valid = rxv; bus1.tx_ready = txr; bus1.err_clr = clr; end
         default: begin bus2.din = {op, pl}; bus2.rx_valid = rxv; bus2.tx_ready = txr; bus2.err_clr = clr; end
      endcase
      @(posedge CLK);
      modelStep(i, op, pl, rxv, txr, clr);
      #1;
      idleInputs();
   endtask

   task automatic cmd(input int i, input logic [1:0] op, input logic [15:0] pl, input bit txr);
      applyStimulus(i, op, pl, 1'b1, txr, 1'b0);
   endtask

   task automatic pinOut(input int i, input string name, input logic [15:0] d, input logic v,
                         input logic o, input logic r);
      logic [15:0] ad;
      logic av, ao, ar;
      getOut(i, ad, av, ao, ar);
      checkOutput({name, " dout"}, ad, d);
      checkOutput({name, " tx_valid"}, 16'(av), 16'(v));
      checkOutput({name, " err_ovf"}, 16'(ao), 16'(o));
      checkOutput({name, " err_range"}, 16'(ar), 16'(r));
   endtask

   always @(negedge CLK) begin
      if (checking) begin
         for (int i = 0; i < 3; i++) begin
            logic [15:0] d;
            logic v, o, r;
            getOut(i, d, v, o, r);
            checkOutput($sformatf("model%0d dout", i), d, mDout[i]);
            checkOutput($sformatf("model%0d tx_valid", i), 16'(v), 16'(mTxv[i]));
            checkOutput($sformatf("model%0d err_ovf", i), 16'(o), 16'(mOvf[i]));
            checkOutput($sformatf("model%0d err_range", i), 16'(r), 16'(mRng[i]));
         end
      end
   end

   initial begin
      idleInputs();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      modelReset();
      checking = 1;
      #2;
      pinOut(0, "reset0", 16'h0, 0, 0, 0);
      pinOut(2, "reset2", 16'h0, 0, 0, 0);
      @(posedge CLK); @(posedge CLK); #1;
      rst_n = 1'b1;

      // Burst write/read, simultaneous accept plus reload, read-pointer end value
      cmd(0, 2'd0, 16'h10, 0);
      cmd(0, 2'd1, 16'hA5, 0);
      cmd(0, 2'd1, 16'h5A, 0);
      cmd(0, 2'd1, 16'hC3, 0);
      cmd(0, 2'd2, 16'h10, 0);
      cmd(0, 2'd3, 16'h0, 1);  pinOut(0, "burst rd0", 16'hA5, 1, 0, 0);
      cmd(0, 2'd3, 16'h0, 1);  pinOut(0, "burst rd1", 16'h5A, 1, 0, 0);
      cmd(0, 2'd3, 16'h0, 1);  pinOut(0, "rd_ptr 0x12", 16'hC3, 1, 0, 0);
      applyStimulus(0, 2'd0, 16'h0, 0, 1, 0);
      pinOut(0, "accept", 16'hC3, 0, 0, 0);

      // Pointer wrap at 0xFF
      cmd(0, 2'd0, 16'hFF, 0);
      cmd(0, 2'd1, 16'h11, 0);
      cmd(0, 2'd1, 16'h22, 0);
      cmd(0, 2'd1, 16'h44, 0);
      cmd(0, 2'd2, 16'hFF, 0);
      cmd(0, 2'd3, 16'h0, 1);  pinOut(0, "wrap rd ff", 16'h11, 1, 0, 0);
      cmd(0, 2'd3, 16'h0, 1);  pinOut(0, "wrap rd 00", 16'h22, 1, 0, 0);
      cmd(0, 2'd3, 16'h0, 1);  pinOut(0, "wrap wr_ptr 01", 16'h44, 1, 0, 0);
      applyStimulus(0, 2'd0, 16'h0, 0, 1, 0);

      // Backpressure, overflow, clear, and set-beats-clear
      cmd(0, 2'd2, 16'h10, 0);
      cmd(0, 2'd3, 16'h0, 0);  pinOut(0, "bp first", 16'hA5, 1, 0, 0);
      cmd(0, 2'd3, 16'h0, 0);  pinOut(0, "bp dropped", 16'hA5, 1, 1, 0);
      applyStimulus(0, 2'd0, 16'h0, 0, 1, 0);
      pinOut(0, "bp accept", 16'hA5, 0, 1, 0);
      cmd(0, 2'd3, 16'h0, 1);  pinOut(0, "bp advanced once", 16'h5A, 1, 1, 0);
      applyStimulus(0, 2'd0, 16'h0, 0, 1, 0);
      applyStimulus(0, 2'd0, 16'h0, 0, 0, 1);
      pinOut(0, "err_clr", 16'h5A, 0, 0, 0);
      cmd(0, 2'd3, 16'h0, 0);
      applyStimulus(0, 2'd3, 16'h0, 1, 0, 1);
      pinOut(0, "set beats clr", 16'hC3, 1, 1, 0);
      applyStimulus(0, 2'd0, 16'h0, 0, 1, 1);

      // Read-after-write on consecutive edges
      cmd(0, 2'd0, 16'h40, 0);
      cmd(0, 2'd2, 16'h40, 0);
      cmd(0, 2'd1, 16'h99, 0);
      cmd(0, 2'd3, 16'h0, 1);  pinOut(0, "raw", 16'h99, 1, 0, 0);

      // MEM_DEPTH=200: wrap at 199 and out-of-range accesses
      cmd(1, 2'd0, 16'hC7, 0);
      cmd(1, 2'd1, 16'h12, 0);
      cmd(1, 2'd1, 16'h34, 0);
      cmd(1, 2'd2, 16'hC7, 0);
      cmd(1, 2'd3, 16'h0, 1);  pinOut(1, "d200 rd c7", 16'h12, 1, 0, 0);
      cmd(1, 2'd3, 16'h0, 1);  pinOut(1, "d200 wrap", 16'h34, 1, 0, 0);
      cmd(1, 2'd0, 16'hC8, 0);
      cmd(1, 2'd1, 16'h33, 1);  pinOut(1, "range wr", 16'h34, 0, 0, 1);
      applyStimulus(1, 2'd0, 16'h0, 0, 0, 1);
      cmd(1, 2'd1, 16'h55, 0);  pinOut(1, "wr_ptr held", 16'h34, 0, 0, 1);
      cmd(1, 2'd2, 16'hC8, 0);
      cmd(1, 2'd3, 16'h0, 0);  pinOut(1, "range rd", 16'h0, 1, 0, 1);
      applyStimulus(1, 2'd0, 16'h0, 0, 1, 1);
      pinOut(1, "range clr", 16'h0, 0, 0, 0);

      // AUTO_INC=0, 16-bit data, 10-bit pointers, reset mid-sequence
      cmd(2, 2'd0, 16'h3FF, 0);
      cmd(2, 2'd1, 16'hBEEF, 0);
      cmd(2, 2'd2, 16'h3FF, 0);
      cmd(2, 2'd3, 16'h0, 1);  pinOut(2, "static rd0", 16'hBEEF, 1, 0, 0);
      cmd(2, 2'd3, 16'h0, 1);  pinOut(2, "static rd1", 16'hBEEF, 1, 0, 0);
      rst_n = 1'b0;
      modelReset();
      #2;
      pinOut(2, "async reset", 16'h0, 0, 0, 0);
      @(posedge CLK); #1;
      rst_n = 1'b1;
      cmd(2, 2'd2, 16'h3FF, 0);
      cmd(2, 2'd3, 16'h0, 1);  pinOut(2, "mem retained", 16'hBEEF, 1, 0, 0);
      applyStimulus(2, 2'd0, 16'h0, 0, 1, 0);

      @(posedge CLK); @(posedge CLK);
      checking = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
